register_map: RTL and testbench

Architectural register map and tag table for the out-of-order core. It is the responder for the three register-map interfaces driven by the reorder buffer:
- **tag_wr**: renames the destination of a newly dispatched instruction.
- **dest_wr**: writes the retired value and clears the pending state.
- **regmap_lookup**: returns data, tag and ready for two source operands.

It holds one entry per architectural register. A pipeline redirect from the reorder buffer discards all in-flight renames.

---
 rtl/register_map_if.sv | 45 ++++
 rtl/register_map.sv | 91 +++++++++
 tb/tb_register_map.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_map_if.sv
// Register-map bus interfaces between the reorder buffer (master) and the
// architectural register map (slave).
//   regmap_tag_wr_if   : dispatch rename   (wr_en, rdest, tag)
//   regmap_dest_wr_if  : retire write      (wr_en, rdest, tag, data)
//   regmap_lookup_if   : two-port lookup   (rsrc[0:1] in; data/tag/rdy[0:1] out)

interface regmap_tag_wr_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TAG_WIDTH      = 6
);
  logic                      wr_en;
  logic [REG_ADDR_WIDTH-1:0] rdest;
  logic [TAG_WIDTH-1:0]      tag;

  modport master (output wr_en, rdest, tag);
  modport slave  (input  wr_en, rdest, tag);
endinterface

interface regmap_dest_wr_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TAG_WIDTH      = 6
);
  logic                      wr_en;
  logic [REG_ADDR_WIDTH-1:0] rdest;
  logic [TAG_WIDTH-1:0]      tag;
  logic [DATA_WIDTH-1:0]     data;

  modport master (output wr_en, rdest, tag, data);
  modport slave  (input  wr_en, rdest, tag, data);
endinterface

interface regmap_lookup_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TAG_WIDTH      = 6
);
  logic [REG_ADDR_WIDTH-1:0] rsrc [0:1];
  logic [DATA_WIDTH-1:0]     data [0:1];
  logic [TAG_WIDTH-1:0]      tag  [0:1];
  logic                      rdy  [0:1];

  modport master (output rsrc, input  data, tag, rdy);
  modport slave  (input  rsrc, output data, tag, rdy);
endinterface

// File: rtl/register_map.sv
// Architectural register map and tag table for the out-of-order core.
// Holds {data, tag, rdy} per architectural register; register 0 reads as
// {0, 0, 1} and ignores writes.
// Ports:
//   clk           clock
//   rst           synchronous active-high reset (all entries -> {0, 0, 1})
//   i_flush       redirect: all rdy -> 1, renames in the same cycle dropped
//   tag_wr        rename strobe from dispatch (slave)
//   dest_wr       retire write from the reorder buffer (slave)
//   regmap_lookup two combinational source-operand lookups (slave)

module register_map #(
  parameter int DATA_WIDTH     = 32,
  parameter int ROB_DEPTH      = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  regmap_tag_wr_if.slave         tag_wr,
  regmap_dest_wr_if.slave        dest_wr,
  regmap_lookup_if.slave         regmap_lookup
);

  localparam int          TAG_WIDTH = $clog2(ROB_DEPTH);
  localparam int unsigned NUM_REGS  = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_REGS];
  logic                  rdy_q  [NUM_REGS];

  logic [NUM_REGS-1:0] rename_hit;
  logic [NUM_REGS-1:0] retire_hit;

  // Per-entry strobe decode; entry 0 never matches so it keeps its reset value.
  always_comb begin
    rename_hit = '0;
    retire_hit = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      rename_hit[i] = tag_wr.wr_en && !i_flush &&
                      (tag_wr.rdest == REG_ADDR_WIDTH'(i));
      retire_hit[i] = dest_wr.wr_en && (dest_wr.rdest == REG_ADDR_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        rdy_q[i]  <= 1'b1;
      end else begin
        // Retired data lands even during a flush or a same-cycle rename.
        if (retire_hit[i]) begin
          data_q[i] <= dest_wr.data;
        end
        // Tags are left stale on flush; they are meaningless while rdy=1.
        if (i_flush) begin
          rdy_q[i] <= 1'b1;
        end else if (rename_hit[i]) begin
          tag_q[i] <= tag_wr.tag;
          rdy_q[i] <= 1'b0;
        end else if (retire_hit[i] && !rdy_q[i] && (tag_q[i] == dest_wr.tag)) begin
          rdy_q[i] <= 1'b1;
        end
      end
    end
  end

  // Lookup sees stored state plus a retire bypass; a same-cycle rename is
  // deliberately invisible so a dispatching instruction reads its old sources.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      regmap_lookup.data[p] = '0;
      regmap_lookup.tag[p]  = '0;
      regmap_lookup.rdy[p]  = 1'b1;
      if (regmap_lookup.rsrc[p] != '0) begin
        regmap_lookup.data[p] = data_q[regmap_lookup.rsrc[p]];
        regmap_lookup.tag[p]  = tag_q[regmap_lookup.rsrc[p]];
        regmap_lookup.rdy[p]  = rdy_q[regmap_lookup.rsrc[p]];
        if (dest_wr.wr_en && (dest_wr.rdest == regmap_lookup.rsrc[p]) &&
            !rdy_q[regmap_lookup.rsrc[p]] &&
            (tag_q[regmap_lookup.rsrc[p]] == dest_wr.tag)) begin
          regmap_lookup.data[p] = dest_wr.data;
          regmap_lookup.rdy[p]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_map.sv
// Self-checking bench for register_map: expected lookup results are queued
// as stimulus is driven and compared against the lookup outputs mid-cycle.

module tb_register_map;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst;
  logic i_flush;

  regmap_tag_wr_if  #(.REG_ADDR_WIDTH(AW), .TAG_WIDTH(TW))                  tw ();
  regmap_dest_wr_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dw ();
  regmap_lookup_if  #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .TAG_WIDTH(TW)) lk ();

  register_map #(.DATA_WIDTH(DW), .ROB_DEPTH(64), .REG_ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (i_flush),
    .tag_wr       (tw),
    .dest_wr      (dw),
    .regmap_lookup(lk)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned port;
    logic [31:0] data;
    logic [5:0]  tag;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string name, input int unsigned port,
                      input logic [31:0] d, input logic [5:0] t, input logic r);
    exp_t e;
    e.name = name; e.port = port; e.data = d; e.tag = t; e.rdy = r;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tw.wr_en = 1'b0;
    dw.wr_en = 1'b0;
    i_flush  = 1'b0;
  endtask

  task automatic look(input logic [4:0] a, input logic [4:0] b);
    lk.rsrc[0] = a;
    lk.rsrc[1] = b;
  endtask

  task automatic rename(input logic [4:0] r, input logic [5:0] t);
    tw.wr_en = 1'b1; tw.rdest = r; tw.tag = t;
  endtask

  task automatic retire(input logic [4:0] r, input logic [5:0] t, input logic [31:0] d);
    dw.wr_en = 1'b1; dw.rdest = r; dw.tag = t; dw.data = d;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    idle();
    look(5'd5, 5'd31);
    repeat (2) tick();
    rst = 1'b0;
    push("reset r5", 0, 32'h0, 6'd0, 1'b1);
    push("reset r31", 1, 32'h0, 6'd0, 1'b1);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if ({lk.data[e.port], lk.tag[e.port], lk.rdy[e.port]} !== {e.data, e.tag, e.rdy}) begin
        errors++;
        $display("FAIL %s: data=%h tag=%0d rdy=%b, expected data=%h tag=%0d rdy=%b", e.name, lk.data[e.port], lk.tag[e.port], lk.rdy[e.port], e.data, e.tag, e.rdy);
      end
    end
  endtask

  task automatic test_rename_retire();
    exp_t e;
    for (int step = 0; step < 3; step++) begin
      tick();
      case (step)
        0: begin
          rename(5'd3, 6'd7); tick(); idle(); look(5'd3, 5'd0);
          push("rename r3 pending", 0, 32'h0, 6'd7, 1'b0);
          push("r0 constant", 1, 32'h0, 6'd0, 1'b1);
        end
        1: begin
          retire(5'd3, 6'd7, 32'hDEADBEEF);
          push("retire bypass r3", 0, 32'hDEADBEEF, 6'd7, 1'b1);
        end
        default: begin
          idle();
          push("retire stored r3", 0, 32'hDEADBEEF, 6'd7, 1'b1);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if ({lk.data[e.port], lk.tag[e.port], lk.rdy[e.port]} !== {e.data, e.tag, e.rdy}) begin
          errors++;
          $display("FAIL %s: data=%h tag=%0d rdy=%b, expected data=%h tag=%0d rdy=%b", e.name, lk.data[e.port], lk.tag[e.port], lk.rdy[e.port], e.data, e.tag, e.rdy);
        end
      end
    end
  endtask

  task automatic test_stale_retire();
    exp_t e;
    tick(); rename(5'd3, 6'd7);
    tick(); rename(5'd3, 6'd9);
    for (int step = 0; step < 4; step++) begin
      tick();
      idle();
      look(5'd3, 5'd0);
      case (step)
        0: begin
          retire(5'd3, 6'd7, 32'h11);
          push("stale retire no bypass", 0, 32'hDEADBEEF, 6'd9, 1'b0);
        end
        1: push("stale retire stored", 0, 32'h11, 6'd9, 1'b0);
        2: begin
          retire(5'd3, 6'd9, 32'h22);
          push("matching retire bypass", 0, 32'h22, 6'd9, 1'b1);
        end
        default: push("matching retire stored", 0, 32'h22, 6'd9, 1'b1);
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if ({lk.data[e.port], lk.tag[e.port], lk.rdy[e.port]} !== {e.data, e.tag, e.rdy}) begin
          errors++;
          $display("FAIL %s: data=%h tag=%0d rdy=%b, expected data=%h tag=%0d rdy=%b", e.name, lk.data[e.port], lk.tag[e.port], lk.rdy[e.port], e.data, e.tag, e.rdy);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    tick(); rename(5'd8, 6'd4);
    for (int step = 0; step < 3; step++) begin
      tick();
      idle();
      look(5'd0, 5'd8);
      case (step)
        0: push("r8 pending", 1, 32'h0, 6'd4, 1'b0);
        1: begin
          retire(5'd8, 6'd4, 32'h55);
          rename(5'd8, 6'd12);
          push("bypass ignores same-cycle rename", 1, 32'h55, 6'd4, 1'b1);
        end
        default: push("rename beats retire ready", 1, 32'h55, 6'd12, 1'b0);
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if ({lk.data[e.port], lk.tag[e.port], lk.rdy[e.port]} !== {e.data, e.tag, e.rdy}) begin
          errors++;
          $display("FAIL %s: data=%h tag=%0d rdy=%b, expected data=%h tag=%0d rdy=%b", e.name, lk.data[e.port], lk.tag[e.port], lk.rdy[e.port], e.data, e.tag, e.rdy);
        end
      end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    tick(); rename(5'd1, 6'd1);
    tick(); rename(5'd2, 6'd2);
    tick(); rename(5'd3, 6'd3);
    for (int step = 0; step < 4; step++) begin
      if (step < 3) tick();
      case (step)
        0: begin
          idle(); look(5'd1, 5'd2);
          push("pre-flush r1", 0, 32'h0, 6'd1, 1'b0);
          push("pre-flush r2", 1, 32'h0, 6'd2, 1'b0);
        end
        1: begin
          i_flush = 1'b1;
          rename(5'd4, 6'd5);
          retire(5'd1, 6'd1, 32'hAA);
          look(5'd1, 5'd4);
          push("flush-cycle bypass r1", 0, 32'hAA, 6'd1, 1'b1);
          push("flush-cycle r4", 1, 32'h0, 6'd0, 1'b1);
        end
        2: begin
          idle(); look(5'd1, 5'd2);
          push("post-flush r1", 0, 32'hAA, 6'd1, 1'b1);
          push("post-flush r2", 1, 32'h0, 6'd2, 1'b1);
        end
        default: begin
          look(5'd3, 5'd4);
          push("post-flush r3", 0, 32'h22, 6'd3, 1'b1);
          push("post-flush r4 rename dropped", 1, 32'h0, 6'd0, 1'b1);
        end
      endcase
      if (step < 3) @(negedge clk);
      else #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if ({lk.data[e.port], lk.tag[e.port], lk.rdy[e.port]} !== {e.data, e.tag, e.rdy}) begin
          errors++;
          $display("FAIL %s: data=%h tag=%0d rdy=%b, expected data=%h tag=%0d rdy=%b", e.name, lk.data[e.port], lk.tag[e.port], lk.rdy[e.port], e.data, e.tag, e.rdy);
        end
      end
    end
  endtask

  task automatic test_reg0();
    exp_t e;
    for (int step = 0; step < 2; step++) begin
      tick();
      idle();
      look(5'd0, 5'd0);
      if (step == 0) begin
        rename(5'd0, 6'd3);
        retire(5'd0, 6'd3, 32'hFF);
      end
      push("r0 port0", 0, 32'h0, 6'd0, 1'b1);
      push("r0 port1", 1, 32'h0, 6'd0, 1'b1);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if ({lk.data[e.port], lk.tag[e.port], lk.rdy[e.port]} !== {e.data, e.tag, e.rdy}) begin
          errors++;
          $display("FAIL %s: data=%h tag=%0d rdy=%b, expected data=%h tag=%0d rdy=%b", e.name, lk.data[e.port], lk.tag[e.port], lk.rdy[e.port], e.data, e.tag, e.rdy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    tick(); rename(5'd5, 6'd10);
    tick(); rename(5'd5, 6'd11);
    for (int step = 0; step < 2; step++) begin
      tick();
      idle();
      if (step == 0) begin
        look(5'd5, 5'd0);
        push("back-to-back rename last wins", 0, 32'h0, 6'd11, 1'b0);
      end else begin
        look(5'd5, 5'd6);
        push("retire r5 alongside rename r6", 0, 32'h77, 6'd11, 1'b1);
        push("rename r6 alongside retire r5", 1, 32'h0, 6'd20, 1'b0);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if ({lk.data[e.port], lk.tag[e.port], lk.rdy[e.port]} !== {e.data, e.tag, e.rdy}) begin
          errors++;
          $display("FAIL %s: data=%h tag=%0d rdy=%b, expected data=%h tag=%0d rdy=%b", e.name, lk.data[e.port], lk.tag[e.port], lk.rdy[e.port], e.data, e.tag, e.rdy);
        end
      end
      if (step == 0) begin
        tick();
        rename(5'd6, 6'd20);
        retire(5'd5, 6'd11, 32'h77);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    tick();
    rename(5'd7, 6'd1);
    retire(5'd6, 6'd20, 32'h99);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    for (int step = 0; step < 2; step++) begin
      if (step == 0) look(5'd6, 5'd7);
      else look(5'd1, 5'd3);
      push("mid-op reset port0", 0, 32'h0, 6'd0, 1'b1);
      push("mid-op reset port1", 1, 32'h0, 6'd0, 1'b1);
      if (step == 0) @(negedge clk);
      else #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if ({lk.data[e.port], lk.tag[e.port], lk.rdy[e.port]} !== {e.data, e.tag, e.rdy}) begin
          errors++;
          $display("FAIL %s: data=%h tag=%0d rdy=%b, expected data=%h tag=%0d rdy=%b", e.name, lk.data[e.port], lk.tag[e.port], lk.rdy[e.port], e.data, e.tag, e.rdy);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_flush = 1'b0;
    tw.wr_en = 1'b0; tw.rdest = '0; tw.tag = '0;
    dw.wr_en = 1'b0; dw.rdest = '0; dw.tag = '0; dw.data = '0;
    lk.rsrc[0] = '0; lk.rsrc[1] = '0;

    test_reset();
    test_rename_retire();
    test_stale_retire();
    test_same_cycle();
    test_flush();
    test_reg0();
    test_back_to_back();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
